// File: rtl/discrete_mapper.sv
`default_nettype none
// ============================================================================
// Module   : discrete_mapper
// Brief    : Discrete-logic NES mapper (AxROM/UxROM/CNROM/GxROM by MODE) with
//            RMW double-store filter and LED stretcher. Define BUS_CONFLICT_EN
//            to AND written data with the flash byte at the write address.
// Revision : 1.0
// ============================================================================
module discrete_mapper #(
  parameter int MODE     = 0,
  parameter int PRG_AW   = 19,
  parameter int CHR_AW   = 17,
  parameter int MIRROR   = 1,
  parameter int LED_HOLD = 4095
) (
  input  logic                m2,
  input  logic                reset,
  input  logic                romsel,
  input  logic                cpu_rw_in,
  input  logic [14:0]         cpu_addr_in,
  input  logic [7:0]          cpu_data_in,
  input  logic [7:0]          prg_rom_data,
  output logic [PRG_AW-13:0]  cpu_addr_out,
  output logic                cpu_rd_out,
  output logic                cpu_wr_out,
  output logic                cpu_flash_ce,
  input  logic                ppu_rd_in,
  input  logic                ppu_wr_in,
  input  logic [3:0]          ppu_addr_in,
  output logic                ppu_rd_out,
  output logic                ppu_wr_out,
  output logic [CHR_AW-11:0]  ppu_addr_out,
  output logic                ppu_flash_ce,
  output logic                ppu_sram_ce,
  output logic                ppu_ciram_a10,
  output logic                ppu_ciram_ce,
  output logic                led
);

  localparam int          c_prg_ow   = PRG_AW - 12;
  localparam int          c_chr_ow   = CHR_AW - 10;
  localparam logic [15:0] c_led_hold = 16'(LED_HOLD);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("discrete_mapper: MODE must be 0..3");
  end
  if (PRG_AW < 15 || PRG_AW > 22) begin : g_bad_prg_aw
    $error("discrete_mapper: PRG_AW must be 15..22");
  end
  if (CHR_AW < 13 || CHR_AW > 20) begin : g_bad_chr_aw
    $error("discrete_mapper: CHR_AW must be 13..20");
  end
  if (LED_HOLD < 1 || LED_HOLD > 65535) begin : g_bad_led_hold
    $error("discrete_mapper: LED_HOLD must be 1..65535");
  end

  logic        w_strobe;
  logic        w_accept;
  logic [7:0]  w_wr_data;
  logic [7:0]  r_bank;
  logic        r_prev_wr;
  logic [15:0] r_led_cnt;
  logic [31:0] w_prg_full;
  logic [31:0] w_chr_full;
  logic        w_a13;

  assign w_strobe = ~romsel & ~cpu_rw_in;
  // Only the first store of a back-to-back pair lands (6502 RMW dummy write).
  assign w_accept = w_strobe & ~r_prev_wr;
  assign w_a13    = ppu_addr_in[3];

`ifdef BUS_CONFLICT_EN
  assign w_wr_data = cpu_data_in & prg_rom_data;
`else
  assign w_wr_data = cpu_data_in;
  logic w_unused_prg_data;
  assign w_unused_prg_data = &{1'b0, prg_rom_data};
`endif

  always_ff @(posedge m2) begin
    if (reset) begin
      r_bank    <= 8'd0;
      r_prev_wr <= 1'b0;
      r_led_cnt <= 16'd0;
    end else begin
      r_prev_wr <= w_strobe;
      if (w_accept) begin
        r_bank    <= w_wr_data;
        r_led_cnt <= c_led_hold;
      end else if (r_led_cnt != 16'd0) begin
        r_led_cnt <= r_led_cnt - 16'd1;
      end
    end
  end

  // Full-width bank/address concatenations, truncated to the configured size.
  always_comb begin
    w_prg_full = 32'd0;
    case (MODE)
      0:       w_prg_full = {21'd0, r_bank, cpu_addr_in[14:12]};
      1:       w_prg_full = cpu_addr_in[14] ? 32'hFFFF_FFFF
                                            : {22'd0, r_bank, cpu_addr_in[13:12]};
      2:       w_prg_full = {29'd0, cpu_addr_in[14:12]};
      3:       w_prg_full = {27'd0, r_bank[5:4], cpu_addr_in[14:12]};
      default: w_prg_full = 32'd0;
    endcase
  end

  always_comb begin
    w_chr_full   = {29'd0, ppu_addr_in[2:0]};
    ppu_flash_ce = 1'b1;
    ppu_sram_ce  = w_a13;
    case (MODE)
      2: begin
        w_chr_full   = {21'd0, r_bank, ppu_addr_in[2:0]};
        ppu_flash_ce = w_a13;
        ppu_sram_ce  = 1'b1;
      end
      3: begin
        w_chr_full   = {27'd0, r_bank[1:0], ppu_addr_in[2:0]};
        ppu_flash_ce = w_a13;
        ppu_sram_ce  = 1'b1;
      end
      default: begin
        w_chr_full   = {29'd0, ppu_addr_in[2:0]};
        ppu_flash_ce = 1'b1;
        ppu_sram_ce  = w_a13;
      end
    endcase
  end

  always_comb begin
    ppu_ciram_a10 = 1'b0;
    if (MODE == 0) begin
      ppu_ciram_a10 = r_bank[4];
    end else if (MIRROR == 0) begin
      ppu_ciram_a10 = ppu_addr_in[1];
    end else begin
      ppu_ciram_a10 = ppu_addr_in[0];
    end
  end

  assign cpu_addr_out = w_prg_full[c_prg_ow-1:0];
  assign ppu_addr_out = w_chr_full[c_chr_ow-1:0];
  assign cpu_rd_out   = ~cpu_rw_in;
  assign cpu_wr_out   = 1'b1;
  assign cpu_flash_ce = romsel;
  assign ppu_rd_out   = ppu_rd_in;
  assign ppu_wr_out   = ppu_wr_in;
  assign ppu_ciram_ce = ~w_a13;
  assign led          = (r_led_cnt != 16'd0) | ~romsel;

  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, cpu_addr_in[11:0], w_prg_full, w_chr_full};

endmodule
`default_nettype wire

// File: tb/tb_discrete_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_discrete_mapper
// Brief    : Four mapper instances (one per MODE) on a shared bus, checked
//            every cycle against a spec-level model plus literal expectations.
// Revision : 1.0
// ============================================================================
module tb_discrete_mapper;

  logic        m2;
  logic        reset;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic [7:0]  prg_rom_data;
  logic        ppu_rd_in;
  logic        ppu_wr_in;
  logic [3:0]  ppu_addr_in;

  logic [6:0] prg0, prg1;
  logic [2:0] prg2;
  logic [9:0] prg3;
  logic [6:0] chr0, chr1;
  logic [4:0] chr2;
  logic [9:0] chr3;
  logic [3:0] rd_o, wr_o, fce_o, prd_o, pwr_o, pfce_o, psce_o, ca10_o, cce_o, led_o;

  int md[4]   = '{0, 1, 2, 3};
  int paw[4]  = '{19, 19, 15, 22};
  int caw[4]  = '{17, 17, 15, 20};
  int mir[4]  = '{1, 0, 1, 0};
  int hold[4] = '{12, 5, 3, 1};

  int m_bank[4];
  int m_prev[4];
  int m_cnt[4];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  discrete_mapper #(.MODE(0), .PRG_AW(19), .CHR_AW(17), .MIRROR(1), .LED_HOLD(12)) u0 (
    .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .prg_rom_data(prg_rom_data),
    .cpu_addr_out(prg0), .cpu_rd_out(rd_o[0]), .cpu_wr_out(wr_o[0]), .cpu_flash_ce(fce_o[0]),
    .ppu_rd_in(ppu_rd_in), .ppu_wr_in(ppu_wr_in), .ppu_addr_in(ppu_addr_in),
    .ppu_rd_out(prd_o[0]), .ppu_wr_out(pwr_o[0]), .ppu_addr_out(chr0),
    .ppu_flash_ce(pfce_o[0]), .ppu_sram_ce(psce_o[0]), .ppu_ciram_a10(ca10_o[0]),
    .ppu_ciram_ce(cce_o[0]), .led(led_o[0]));

  discrete_mapper #(.MODE(1), .PRG_AW(19), .CHR_AW(17), .MIRROR(0), .LED_HOLD(5)) u1 (
    .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .prg_rom_data(prg_rom_data),
    .cpu_addr_out(prg1), .cpu_rd_out(rd_o[1]), .cpu_wr_out(wr_o[1]), .cpu_flash_ce(fce_o[1]),
    .ppu_rd_in(ppu_rd_in), .ppu_wr_in(ppu_wr_in), .ppu_addr_in(ppu_addr_in),
    .ppu_rd_out(prd_o[1]), .ppu_wr_out(pwr_o[1]), .ppu_addr_out(chr1),
    .ppu_flash_ce(pfce_o[1]), .ppu_sram_ce(psce_o[1]), .ppu_ciram_a10(ca10_o[1]),
    .ppu_ciram_ce(cce_o[1]), .led(led_o[1]));

  discrete_mapper #(.MODE(2), .PRG_AW(15), .CHR_AW(15), .MIRROR(1), .LED_HOLD(3)) u2 (
    .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .prg_rom_data(prg_rom_data),
    .cpu_addr_out(prg2), .cpu_rd_out(rd_o[2]), .cpu_wr_out(wr_o[2]), .cpu_flash_ce(fce_o[2]),
    .ppu_rd_in(ppu_rd_in), .ppu_wr_in(ppu_wr_in), .ppu_addr_in(ppu_addr_in),
    .ppu_rd_out(prd_o[2]), .ppu_wr_out(pwr_o[2]), .ppu_addr_out(chr2),
    .ppu_flash_ce(pfce_o[2]), .ppu_sram_ce(psce_o[2]), .ppu_ciram_a10(ca10_o[2]),
    .ppu_ciram_ce(cce_o[2]), .led(led_o[2]));

  discrete_mapper #(.MODE(3), .PRG_AW(22), .CHR_AW(20), .MIRROR(0), .LED_HOLD(1)) u3 (
    .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .prg_rom_data(prg_rom_data),
    .cpu_addr_out(prg3), .cpu_rd_out(rd_o[3]), .cpu_wr_out(wr_o[3]), .cpu_flash_ce(fce_o[3]),
    .ppu_rd_in(ppu_rd_in), .ppu_wr_in(ppu_wr_in), .ppu_addr_in(ppu_addr_in),
    .ppu_rd_out(prd_o[3]), .ppu_wr_out(pwr_o[3]), .ppu_addr_out(chr3),
    .ppu_flash_ce(pfce_o[3]), .ppu_sram_ce(psce_o[3]), .ppu_ciram_a10(ca10_o[3]),
    .ppu_ciram_ce(cce_o[3]), .led(led_o[3]));

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Spec-level model: bank register, store filter and LED hold counter.
  always @(posedge m2) begin
    bit stb;
    int wd;
    stb = !romsel && !cpu_rw_in;
`ifdef BUS_CONFLICT_EN
    wd = int'(cpu_data_in & prg_rom_data);
`else
    wd = int'(cpu_data_in);
`endif
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        m_bank[k] = 0;
        m_prev[k] = 0;
        m_cnt[k]  = 0;
      end else begin
        if (stb && m_prev[k] == 0) begin
          m_bank[k] = wd;
          m_cnt[k]  = hold[k];
        end else if (m_cnt[k] > 0) begin
          m_cnt[k] = m_cnt[k] - 1;
        end
        m_prev[k] = stb ? 1 : 0;
      end
    end
  end

  function automatic int exp_prg(input int k);
    int a, bk, v;
    a  = int'(cpu_addr_in);
    bk = m_bank[k];
    case (md[k])
      0:       v = bk * 8 + (a >> 12) % 8;
      1:       v = ((a >> 14) % 2 == 1) ? -1 : bk * 4 + (a >> 12) % 4;
      2:       v = (a >> 12) % 8;
      default: v = ((bk >> 4) % 4) * 8 + (a >> 12) % 8;
    endcase
    return v & ((1 << (paw[k] - 12)) - 1);
  endfunction

  function automatic int exp_chr(input int k);
    int lo, bk, v;
    lo = int'(ppu_addr_in) % 8;
    bk = m_bank[k];
    case (md[k])
      2:       v = bk * 8 + lo;
      3:       v = (bk % 4) * 8 + lo;
      default: v = lo;
    endcase
    return v & ((1 << (caw[k] - 10)) - 1);
  endfunction

  always @(negedge m2) begin
    int a_prg[4];
    int a_chr[4];
    int a13, e_a10;
    if (chk_en) begin
      a_prg[0] = int'(prg0); a_prg[1] = int'(prg1); a_prg[2] = int'(prg2); a_prg[3] = int'(prg3);
      a_chr[0] = int'(chr0); a_chr[1] = int'(chr1); a_chr[2] = int'(chr2); a_chr[3] = int'(chr3);
      a13 = int'(ppu_addr_in[3]);
      for (int k = 0; k < 4; k++) begin
        if (md[k] == 0)      e_a10 = (m_bank[k] >> 4) % 2;
        else if (mir[k] == 1) e_a10 = int'(ppu_addr_in[0]);
        else                 e_a10 = int'(ppu_addr_in[1]);
        check($sformatf("u%0d.cpu_addr_out", k), a_prg[k], exp_prg(k));
        check($sformatf("u%0d.ppu_addr_out", k), a_chr[k], exp_chr(k));
        check($sformatf("u%0d.cpu_rd_out", k), int'(rd_o[k]), int'(!cpu_rw_in));
        check($sformatf("u%0d.cpu_wr_out", k), int'(wr_o[k]), 1);
        check($sformatf("u%0d.cpu_flash_ce", k), int'(fce_o[k]), int'(romsel));
        check($sformatf("u%0d.ppu_rd_out", k), int'(prd_o[k]), int'(ppu_rd_in));
        check($sformatf("u%0d.ppu_wr_out", k), int'(pwr_o[k]), int'(ppu_wr_in));
        check($sformatf("u%0d.ppu_flash_ce", k), int'(pfce_o[k]), (md[k] >= 2) ? a13 : 1);
        check($sformatf("u%0d.ppu_sram_ce", k), int'(psce_o[k]), (md[k] < 2) ? a13 : 1);
        check($sformatf("u%0d.ppu_ciram_ce", k), int'(cce_o[k]), 1 - a13);
        check($sformatf("u%0d.ppu_ciram_a10", k), int'(ca10_o[k]), e_a10);
        check($sformatf("u%0d.led", k), int'(led_o[k]), (m_cnt[k] != 0 || !romsel) ? 1 : 0);
      end
    end
  end

  task automatic drive(input bit rs, input bit rw, input int addr, input int data,
                       input int prg, input int paddr);
    romsel       = rs;
    cpu_rw_in    = rw;
    cpu_addr_in  = 15'(addr);
    cpu_data_in  = 8'(data);
    prg_rom_data = 8'(prg);
    ppu_addr_in  = 4'(paddr);
  endtask

  task automatic tick;
    @(posedge m2);
    #1;
  endtask

  task automatic wr(input int data, input int prg);
    drive(1'b0, 1'b0, 0, data, prg, 0);
    tick();
  endtask

  task automatic idle(input int addr, input int paddr);
    drive(1'b1, 1'b1, addr, 0, 0, paddr);
  endtask

  initial begin
    int n;
    int data_tbl[4];
    data_tbl = '{8'h10, 8'hA5, 8'h3C, 8'h4B};
    reset     = 1'b1;
    ppu_rd_in = 1'b1;
    ppu_wr_in = 1'b1;
    idle(0, 0);
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset state
    idle(0, 0); #1;
    check("reset m0 cpu_addr_out", int'(prg0), 0);
    check("reset m1 cpu_addr_out A14=0", int'(prg1), 0);
    check("reset m0 ciram_a10", int'(ca10_o[0]), 0);
    check("reset m0 led", int'(led_o[0]), 0);
    idle('h4000, 0); #1;
    check("reset m1 cpu_addr_out A14=1", int'(prg1), 127);
    tick();

    // MODE 0: write $13 -> PRG bank 3, CIRAM A10 = 1, LED stretch
    wr('h13, 0);
    idle(0, 0); #1;
    check("m0 $13 prg bank", int'(prg0[6:3]), 3);
    check("m0 $13 ciram_a10", int'(ca10_o[0]), 1);
    n = 0;
    while (led_o[0] && n < 100) begin
      n++;
      tick();
    end
    check("m0 led hold cycles", n, 12);

    // Back-to-back stores: only the first lands
    wr('h05, 0);
    wr('h07, 0);
    idle(0, 0); #1;
    check("m0 back-to-back keeps first", int'(prg0[6:3]), 5);
    tick();
    wr('h05, 0);
    idle(0, 0); tick();
    wr('h07, 0);
    idle(0, 0); #1;
    check("m0 separated keeps second", int'(prg0[6:3]), 7);
    tick();
    // Strobe with romsel=1 does not load but clears the filter
    wr('h05, 0);
    drive(1'b1, 1'b0, 0, 'h09, 0, 0); tick();
    wr('h0A, 0);
    idle(0, 0); #1;
    check("m0 romsel-high breaks pair", int'(prg0[6:3]), 10);
    tick();

    // MODE 1: write $06
    wr('h06, 0);
    idle('h4000, 0); #1;
    check("m1 fixed last bank", int'(prg1), 127);
    idle('h2000, 0); #1;
    check("m1 switchable bank", int'(prg1), 'h1A);
    tick();

    // MODE 2 (CHR_AW=15): write $03
    wr('h03, 0);
    idle(0, 0); #1;
    check("m2 chr bank", int'(chr2[4:3]), 3);
    check("m2 flash_ce A13=0", int'(pfce_o[2]), 0);
    check("m2 sram_ce", int'(psce_o[2]), 1);
    idle(0, 8); #1;
    check("m2 flash_ce A13=1", int'(pfce_o[2]), 1);
    tick();

    // MODE 3: write $FF with flash byte $21
    wr('hFF, 'h21);
    idle(0, 0); #1;
`ifdef BUS_CONFLICT_EN
    check("m3 prg bank", int'(prg3[4:3]), 2);
    check("m3 chr bank", int'(chr3[4:3]), 1);
`else
    check("m3 prg bank", int'(prg3[4:3]), 3);
    check("m3 chr bank", int'(chr3[4:3]), 3);
`endif
    tick();

    // Reset on the same edge as a write; next-cycle strobe accepted
    reset = 1'b1;
    wr('h1F, 'hFF);
    reset = 1'b0;
    drive(1'b0, 1'b0, 0, 'h12, 'hFF, 0); #1;
    check("reset-vs-write bank lost", int'(prg0[6:3]), 0);
    check("reset-vs-write ciram_a10", int'(ca10_o[0]), 0);
    tick();
    idle(0, 0); #1;
    check("post-reset strobe accepted", int'(prg0[6:3]), 2);
    check("post-reset strobe ciram_a10", int'(ca10_o[0]), 1);
    tick();

    // Sweeps across address and PPU patterns for the per-cycle model
    for (int d = 0; d < 4; d++) begin
      wr(data_tbl[d], 'hF0 | d);
      for (int i = 0; i < 16; i++) begin
        idle((i % 8) << 12 | ((i / 8) << 14), i);
        ppu_rd_in = i[0];
        ppu_wr_in = i[1];
        tick();
      end
    end

    @(negedge m2);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
